mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit of the 5-stage RV32I pipeline. Consumes the EX/MEM
//  rv32i_control_word, ALU address and rs2 data, and issues one data-cache access
//  per load/store. Generates byte masks and lane-shifted store data, and
//  sign/zero-extends load data. Stalls the pipeline until the cache responds, then
//  presents the result to the MEM/WB register.
// PARAMETERS
//  TIMEOUT      0   cycles in BUSY before mem_timeout sets; 0 disables watchdog
//  STALL_CNT_W  32  width of stall_count performance counter
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous reset, active-high
//  in_valid       in   1   EX/MEM holds a live instruction
//  ctrl           in   $bits(rv32i_control_word)  control word of that instruction
//  alu_out        in   32  effective byte address
//  rs2_data       in   32  store source data
//  flush          in   1   kill the instruction currently held in MEM
//  d_cache_read   out  1   registered read request
//  d_cache_write  out  1   registered write request
//  d_cache_addr   out  32  word-aligned address {alu_out[31:2],2'b00}
//  d_cache_wdata  out  32  lane-shifted store data
//  d_cache_wmask  out  4   rv32i_mem_wmask byte enables
//  d_cache_resp   in   1   one-cycle completion pulse
//  d_cache_rdata  in   32  read data; valid when d_cache_resp=1
//  stall_mem      out  1   freeze IF..MEM pipeline registers
//  load_data      out  32  extended load result for writeback
//  result_valid   out  1   load_data/store completion valid this cycle
//  misaligned     out  1   current op misaligned; no access issued
//  mem_timeout    out  1   sticky watchdog flag
//  stall_count    out  STALL_CNT_W  cycles with stall_mem=1, wraps
// BEHAVIOUR
//  - mem_op = in_valid & ~flush & (ctrl.d_cache_read | ctrl.d_cache_write) & ~misaligned.
//  - Misaligned: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]!=0. Combinational;
//    no request, no stall, result_valid=0, load_data=0.
//  - FSM states IDLE, BUSY, DONE; reset state is IDLE.
//    IDLE: on mem_op, latch addr/wdata/wmask, set the read or write request, go BUSY.
//    BUSY: hold all request outputs stable until d_cache_resp. On resp, drop the
//      request, latch extended rdata into load_data, go DONE.
//    DONE: unconditionally return to IDLE. Ignore the still-present input op, so it
//      is never re-issued.
//  - stall_mem = (IDLE & mem_op) | BUSY. stall_mem=0 in DONE, so the pipeline advances
//    at the end of DONE. Minimum op latency: accept in cycle 0, request in cycle 1,
//    resp in cycle k>=1, DONE in cycle k+1.
//  - result_valid = DONE & ~killed. killed is set by flush during BUSY/DONE and
//    cleared on entering IDLE. A flushed BUSY access still waits for resp; the cache
//    cannot abort.
//  - Write mask: sb 4'b0001<<addr[1:0]; sh 4'b0011<<{addr[1],1'b0}; sw 4'b1111.
//    wdata = rs2_data << (8*addr[1:0]).
//  - Loads: lane = rdata >> (8*addr[1:0]). lb/lh sign-extend; lbu/lhu zero-extend;
//    lw takes rdata as-is. Stores leave load_data unchanged.
//  - Watchdog (TIMEOUT>0): counts BUSY cycles and clears on leaving BUSY. Reaching
//    TIMEOUT sets mem_timeout; FSM behaviour is unchanged. Only rst clears the flag.
//  - Reset values: all outputs 0, state IDLE, stall_count 0, killed 0.
//    A reset mid-BUSY drops the request immediately; a later late resp is ignored
//    in IDLE.
//  - read and write requests are never both 1; ctrl asserting both is illegal
//    (bench assertion).
// TESTING
//  - lw at 0x100, resp after 3 cycles with rdata 0xDEADBEEF: d_cache_read held
//    3 cycles, stall_mem=1 for 4 cycles, DONE load_data=0xDEADBEEF, result_valid=1.
//  - lb addr 0x103, rdata 0x80FF_FF7F: load_data=0xFFFFFF80.
//    lbu: 0x00000080. lh 0x102: 0xFFFF80FF.
//  - sb addr 0x201, rs2 0x000000AB: wmask 4'b0010, wdata 0x0000AB00, addr 0x200.
//    sh 0x202: wmask 4'b1100.
//  - lw addr 0x102: misaligned=1, no request, stall_mem=0, result_valid=0.
//  - flush during BUSY, resp 2 cycles later: request held until resp, DONE with
//    result_valid=0, no re-issue.
//  - TIMEOUT=4, no resp: mem_timeout=1 on 4th BUSY cycle, stays 1. rst mid-BUSY:
//    next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Shared types and the data-cache bus used by the MEM-stage load/store unit.
//   rv32i_control_word : subset of the EX/MEM control word seen by the LSU
//   rv32i_mem_wmask    : per-byte write enables
//   mem_stage_lsu_if   : request/response bus between the LSU (master) and
//                        the data cache (slave)
//     d_cache_read/write : registered request strobes, held until d_cache_resp
//     d_cache_addr       : word-aligned byte address
//     d_cache_wdata      : store data already shifted into its byte lanes
//     d_cache_wmask      : byte enables for stores
//     d_cache_resp       : one-cycle completion pulse from the cache
//     d_cache_rdata      : full read word, valid with d_cache_resp
package mem_stage_lsu_pkg;

  typedef struct packed {
    logic       d_cache_read;
    logic       d_cache_write;
    logic [2:0] funct3;
  } rv32i_control_word;

  typedef logic [3:0] rv32i_mem_wmask;

endpackage

interface mem_stage_lsu_if;
  import mem_stage_lsu_pkg::*;

  logic           d_cache_read;
  logic           d_cache_write;
  logic [31:0]    d_cache_addr;
  logic [31:0]    d_cache_wdata;
  rv32i_mem_wmask d_cache_wmask;
  logic           d_cache_resp;
  logic [31:0]    d_cache_rdata;

  modport master (
    output d_cache_read, d_cache_write, d_cache_addr, d_cache_wdata, d_cache_wmask,
    input  d_cache_resp, d_cache_rdata
  );

  modport slave (
    input  d_cache_read, d_cache_write, d_cache_addr, d_cache_wdata, d_cache_wmask,
    output d_cache_resp, d_cache_rdata
  );

endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the 5-stage RV32I pipeline. Issues one
// data-cache access per load/store, holds the pipeline until the cache
// responds, and hands the extended load result to MEM/WB.
//
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   in_valid       : EX/MEM holds a live instruction
//   ctrl           : its control word (read/write strobes, funct3 width/sign)
//   alu_out        : effective byte address
//   rs2_data       : store source data
//   flush          : kill the instruction currently held in MEM
//   dbus           : data-cache request/response bus (master side)
//   stall_mem      : freeze IF..MEM pipeline registers
//   load_data      : extended load result for writeback
//   result_valid   : op completed this cycle and was not flushed
//   misaligned     : current op is misaligned; nothing is issued for it
//   mem_timeout    : sticky watchdog flag (TIMEOUT BUSY cycles without resp)
//   stall_count    : wrapping count of cycles with stall_mem=1
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; accepts a new aligned load/store
// BUSY  | request on the bus, waiting for d_cache_resp
// DONE  | result presented for one cycle while the pipeline advances
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT     = 0,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  rv32i_control_word      ctrl,
  input  logic [31:0]            alu_out,
  input  logic [31:0]            rs2_data,
  input  logic                   flush,
  mem_stage_lsu_if.master        dbus,
  output logic                   stall_mem,
  output logic [31:0]            load_data,
  output logic                   result_valid,
  output logic                   misaligned,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic           req_read;
  logic           req_write;
  logic [31:0]    req_addr;
  logic [31:0]    req_wdata;
  rv32i_mem_wmask req_wmask;
  logic [1:0]     op_off;
  logic [2:0]     op_funct3;
  logic [31:0]    load_q;
  logic           killed_q;

  logic           is_mem;
  logic           mis_raw;
  logic           mem_op;
  logic           killed;
  rv32i_mem_wmask wmask_next;
  logic [31:0]    wdata_next;

  // Lane select then sign/zero extension; funct3[2] marks the unsigned forms.
  function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [31:0] lane;
    logic [31:0] res;
    lane = rdata >> {off, 3'b000};
    case (funct3)
      3'b000:  res = {{24{lane[7]}}, lane[7:0]};
      3'b001:  res = {{16{lane[15]}}, lane[15:0]};
      3'b100:  res = {24'b0, lane[7:0]};
      3'b101:  res = {16'b0, lane[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  always_comb begin
    mis_raw    = 1'b0;
    wmask_next = 4'b1111;
    case (ctrl.funct3[1:0])
      2'b00: begin
        mis_raw    = 1'b0;
        wmask_next = 4'b0001 << alu_out[1:0];
      end
      2'b01: begin
        mis_raw    = alu_out[0];
        wmask_next = 4'b0011 << {alu_out[1], 1'b0};
      end
      default: begin
        mis_raw    = |alu_out[1:0];
        wmask_next = 4'b1111;
      end
    endcase
  end

  assign wdata_next = rs2_data << {alu_out[1:0], 3'b000};
  assign is_mem     = in_valid & (ctrl.d_cache_read | ctrl.d_cache_write);
  assign misaligned = is_mem & mis_raw;
  assign mem_op     = is_mem & ~flush & ~misaligned;

  // A flush arriving in DONE kills the result in the same cycle.
  assign killed = killed_q | (flush & ((state == BUSY) | (state == DONE)));

  assign stall_mem    = ((state == IDLE) & mem_op) | (state == BUSY);
  assign result_valid = (state == DONE) & ~killed;
  assign load_data    = misaligned ? 32'b0 : load_q;

  assign dbus.d_cache_read  = req_read;
  assign dbus.d_cache_write = req_write;
  assign dbus.d_cache_addr  = req_addr;
  assign dbus.d_cache_wdata = req_wdata;
  assign dbus.d_cache_wmask = req_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_read  <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= 32'b0;
      req_wdata <= 32'b0;
      req_wmask <= 4'b0;
      op_off    <= 2'b0;
      op_funct3 <= 3'b0;
      load_q    <= 32'b0;
      killed_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          killed_q <= 1'b0;
          if (mem_op) begin
            req_read  <= ctrl.d_cache_read;
            // Read wins if both strobes are set, so the bus never sees both.
            req_write <= ctrl.d_cache_write & ~ctrl.d_cache_read;
            req_addr  <= {alu_out[31:2], 2'b00};
            req_wdata <= wdata_next;
            req_wmask <= wmask_next;
            op_off    <= alu_out[1:0];
            op_funct3 <= ctrl.funct3;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (flush) killed_q <= 1'b1;
          // The cache cannot abort, so a killed access still waits for resp.
          if (dbus.d_cache_resp) begin
            req_read  <= 1'b0;
            req_write <= 1'b0;
            if (req_read) load_q <= extend_load(op_funct3, op_off, dbus.d_cache_rdata);
            state <= DONE;
          end
        end
        DONE: begin
          // The op still sitting in EX/MEM is the one just finished; never re-issue it.
          killed_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          killed_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (stall_mem) stall_count <= stall_count + STALL_CNT_W'(1);
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [WD_W-1:0] wd_left;
      logic            wd_flag;
      logic            wd_tc;

      // wd_left reaches zero in the TIMEOUT-th consecutive BUSY cycle.
      assign wd_tc       = (state == BUSY) && (wd_left == '0);
      assign mem_timeout = wd_flag | wd_tc;

      always_ff @(posedge clk) begin
        if (rst) begin
          wd_left <= '0;
          wd_flag <= 1'b0;
        end else begin
          if (state != BUSY) wd_left <= WD_W'(TIMEOUT - 1);
          else if (wd_left != '0) wd_left <= wd_left - WD_W'(1);
          if (wd_tc) wd_flag <= 1'b1;
        end
      end
    end else begin : g_no_wd
      assign mem_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  rv32i_control_word ctrl;
  logic [31:0]       alu_out;
  logic [31:0]       rs2_data;
  logic              flush;
  logic              stall_mem;
  logic [31:0]       load_data;
  logic              result_valid;
  logic              misaligned;
  logic              mem_timeout;
  logic [31:0]       stall_count;

  mem_stage_lsu_if dbus();

  mem_stage_lsu #(.TIMEOUT(4), .STALL_CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .ctrl         (ctrl),
    .alu_out      (alu_out),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .dbus         (dbus),
    .stall_mem    (stall_mem),
    .load_data    (load_data),
    .result_valid (result_valid),
    .misaligned   (misaligned),
    .mem_timeout  (mem_timeout),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_load = 32'b0;
  int          m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert (!(dbus.d_cache_read === 1'b1 && dbus.d_cache_write === 1'b1)) else begin
        n_err++;
        $error("FAIL req_exclusive observed=11 expected=not both");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  // Reference rules, written from the access width and byte offset.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << nbytes(f3)) - 1) << int'(addr[1:0]);
    return 32'(m & 15);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input logic [31:0] addr);
    logic [63:0] w;
    w = {32'b0, rs2} << (8 * int'(addr[1:0]));
    return w[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int          nb;
    logic [31:0] lane;
    logic [31:0] m;
    logic [31:0] v;
    nb = nbytes(f3);
    if (nb == 4) return rdata;
    lane = rdata >> (8 * int'(addr[1:0]));
    m = 32'((64'd1 << (8 * nb)) - 64'd1);
    v = lane & m;
    if (!f3[2] && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  // Starts at a negedge in IDLE; returns in the idle cycle after the op.
  task automatic run_op(input logic [2:0] f3, input bit is_wr, input logic [31:0] addr,
                        input logic [31:0] rs2, input int lat, input logic [31:0] rdata,
                        input int flush_at);
    bit mis;
    bit killed_exp;
    mis = ref_mis(f3, addr);
    killed_exp = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    ctrl.d_cache_read = !is_wr;
    ctrl.d_cache_write = is_wr;
    ctrl.funct3 = f3;
    alu_out = addr;
    rs2_data = rs2;
    flush = 1'b0;
    #1;
    chk("misaligned", 32'(misaligned), 32'(mis));
    chk("stall_accept", 32'(stall_mem), 32'(!mis));
    chk("req_not_yet", 32'({dbus.d_cache_read, dbus.d_cache_write}), 32'd0);
    if (mis) begin
      chk("load_data_mis", load_data, 32'd0);
      chk("result_valid_mis", 32'(result_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("no_req_mis", 32'({dbus.d_cache_read, dbus.d_cache_write}), 32'd0);
      chk("stall_count", stall_count, 32'(m_stall));
      return;
    end
    m_stall++;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      flush = (c == flush_at);
      if (flush) killed_exp = 1'b1;
      dbus.d_cache_resp = (c == lat);
      dbus.d_cache_rdata = (c == lat) ? rdata : $urandom;
      #1;
      chk("busy_read", 32'(dbus.d_cache_read), 32'(!is_wr));
      chk("busy_write", 32'(dbus.d_cache_write), 32'(is_wr));
      chk("busy_addr", dbus.d_cache_addr, addr & 32'hFFFF_FFFC);
      chk("busy_stall", 32'(stall_mem), 32'd1);
      chk("busy_rvalid", 32'(result_valid), 32'd0);
      if (is_wr) begin
        chk("busy_wmask", 32'(dbus.d_cache_wmask), ref_mask(f3, addr));
        chk("busy_wdata", dbus.d_cache_wdata, ref_wdata(rs2, addr));
      end
      m_stall++;
    end
    @(negedge clk);
    dbus.d_cache_resp = 1'b0;
    dbus.d_cache_rdata = $urandom;
    flush = 1'b0;
    #1;
    if (!is_wr) m_load = ref_load(f3, addr, rdata);
    chk("done_req", 32'({dbus.d_cache_read, dbus.d_cache_write}), 32'd0);
    chk("done_stall", 32'(stall_mem), 32'd0);
    chk("done_rvalid", 32'(result_valid), 32'(!killed_exp));
    chk("done_load_data", load_data, m_load);
    chk("no_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("no_reissue", 32'({dbus.d_cache_read, dbus.d_cache_write}), 32'd0);
    chk("idle_rvalid", 32'(result_valid), 32'd0);
    chk("stall_count", stall_count, 32'(m_stall));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, 32'(dbus.d_cache_read), 32'd0);
    chk({tag, "_write"}, 32'(dbus.d_cache_write), 32'd0);
    chk({tag, "_addr"}, dbus.d_cache_addr, 32'd0);
    chk({tag, "_wdata"}, dbus.d_cache_wdata, 32'd0);
    chk({tag, "_wmask"}, 32'(dbus.d_cache_wmask), 32'd0);
    chk({tag, "_stall"}, 32'(stall_mem), 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_rvalid"}, 32'(result_valid), 32'd0);
    chk({tag, "_misaligned"}, 32'(misaligned), 32'd0);
    chk({tag, "_timeout"}, 32'(mem_timeout), 32'd0);
    chk({tag, "_stall_count"}, stall_count, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    bit          wr;
    int          lat;
    int          fa;
    logic [31:0] a;

    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    ctrl = '0;
    alu_out = 32'b0;
    rs2_data = 32'b0;
    dbus.d_cache_resp = 1'b0;
    dbus.d_cache_rdata = 32'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    run_op(3'b010, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0);
    chk("lw_value", load_data, 32'hDEADBEEF);
    run_op(3'b000, 1'b0, 32'h103, 32'h0, 1, 32'h80FF_FF7F, 0);
    chk("lb_value", load_data, 32'hFFFF_FF80);
    run_op(3'b100, 1'b0, 32'h103, 32'h0, 2, 32'h80FF_FF7F, 0);
    chk("lbu_value", load_data, 32'h0000_0080);
    run_op(3'b001, 1'b0, 32'h102, 32'h0, 1, 32'h80FF_FF7F, 0);
    chk("lh_value", load_data, 32'hFFFF_80FF);
    run_op(3'b000, 1'b1, 32'h201, 32'h0000_00AB, 2, 32'h0, 0);
    chk("sb_wmask", 32'(dbus.d_cache_wmask), 32'h2);
    chk("sb_wdata", dbus.d_cache_wdata, 32'h0000_AB00);
    chk("sb_addr", dbus.d_cache_addr, 32'h200);
    chk("store_keeps_load", load_data, 32'hFFFF_80FF);
    run_op(3'b001, 1'b1, 32'h202, 32'h0000_1234, 1, 32'h0, 0);
    chk("sh_wmask", 32'(dbus.d_cache_wmask), 32'hC);
    run_op(3'b010, 1'b0, 32'h102, 32'h0, 1, 32'h0, 0);
    run_op(3'b010, 1'b1, 32'h301, 32'h5, 1, 32'h0, 0);
    run_op(3'b101, 1'b0, 32'h105, 32'h0, 1, 32'h0, 0);
    run_op(3'b010, 1'b0, 32'h300, 32'h0, 3, 32'h1357_9BDF, 1);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, wr ? 2 : 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = 32'h1000 + 32'($urandom_range(0, 255));
      lat = $urandom_range(1, 3);
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      run_op(f3, wr, a, $urandom, lat, $urandom, fa);
    end

    @(negedge clk);
    in_valid = 1'b1;
    ctrl.d_cache_read = 1'b1;
    ctrl.d_cache_write = 1'b0;
    ctrl.funct3 = 3'b010;
    alu_out = 32'h400;
    #1;
    chk("wd_accept_stall", 32'(stall_mem), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #1;
      chk("wd_timeout", 32'(mem_timeout), 32'(c >= 4));
      chk("wd_read_held", 32'(dbus.d_cache_read), 32'd1);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_all_zero("rst_mid_busy");
    rst = 1'b0;
    dbus.d_cache_resp = 1'b1;
    dbus.d_cache_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dbus.d_cache_resp = 1'b0;
    #1;
    chk("late_resp_req", 32'({dbus.d_cache_read, dbus.d_cache_write}), 32'd0);
    chk("late_resp_rvalid", 32'(result_valid), 32'd0);
    chk("late_resp_load", load_data, 32'd0);
    @(negedge clk);
    #1;
    chk("late_resp_rvalid2", 32'(result_valid), 32'd0);
    chk("late_resp_stall", 32'(stall_mem), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
